// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits
//   per clock through a borrow chain, with the borrow carried between cycles
//   in a register. Start/busy/valid handshake.
//
//   Parameters:
//     WIDTH  operand/result width (>= 2)
//     DIGIT  bits processed per cycle (WIDTH % DIGIT == 0)
//
//   Ports:
//     clk    rising-edge clock
//     rst    asynchronous active-high reset
//     start  request, accepted only while ready=1
//     a, b   minuend/subtrahend, sampled on accept
//     bin    borrow-in, sampled on accept
//     ready  block can accept start (= !busy)
//     busy   computation in progress
//     diff   registered result
//     bout   registered borrow-out of the MSB
//     valid  one-cycle pulse when diff/bout/ovf update
//     ovf    signed overflow flag
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     defined   : ovf = signed overflow of the completed subtraction
//     undefined : ovf tied to 0, no sign-capture registers
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             valid,
    output logic             ovf
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic [DIGIT:0]   sub;
    logic             last;
    logic             accept;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CNT_W'(STEPS - 1));

    // One digit of the borrow chain; the extra top bit is the borrow-out.
    always_comb begin
        sub = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
              - {{DIGIT{1'b0}}, brw};
    end

    // Result fills from the MSB end so after STEPS shifts it is aligned.
    always_comb begin
        r_next                  = r_sh >> DIGIT;
        r_next[WIDTH-1 -: DIGIT] = sub[DIGIT-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state == RUN);
        ready = (state != RUN);
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= bin;
                cnt  <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> DIGIT;
                b_sh <= b_sh >> DIGIT;
                brw  <= sub[DIGIT];
                r_sh <= r_next;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    diff  <= r_next;
                    bout  <= sub[DIGIT];
                    valid <= 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end else if (state == RUN && last) begin
                ovf <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int unsigned W  = 8;
    localparam int unsigned W2 = 16;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle instance
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         ready, busy, bout, valid, ovf;
    logic [W-1:0] diff;

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .busy(busy), .diff(diff), .bout(bout),
        .valid(valid), .ovf(ovf)
    );

    // 16-bit, 4 bits per cycle instance
    logic          start2 = 1'b0;
    logic [W2-1:0] a2 = '0, b2 = '0;
    logic          bin2 = 1'b0;
    logic          ready2, busy2, bout2, valid2, ovf2;
    logic [W2-1:0] diff2;

    serial_subtractor #(.WIDTH(W2), .DIGIT(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .ready(ready2), .busy(busy2), .diff(diff2), .bout(bout2),
        .valid(valid2), .ovf(ovf2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model of the 8-bit instance: an accepted request
    // produces its arithmetic result exactly W cycles later.
    logic         m_busy, m_valid, m_bout, m_ovf;
    logic [W-1:0] m_diff;
    int           m_rem;
    logic [W-1:0] p_diff;
    logic         p_bout, p_ovf;

    always @(posedge clk or posedge rst) begin
        logic [W:0] full;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_bout = 0; m_ovf = 0; m_diff = '0; m_rem = 0;
        end else begin
            m_valid = 0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0; m_valid = 1;
                    m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                end
            end else if (start) begin
                full   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
                p_diff = full[W-1:0];
                p_bout = (int'(a) < int'(b) + int'(bin));
                p_ovf  = OVF_ON && (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
                m_busy = 1; m_rem = W;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            check("cyc_busy",  32'(busy),  32'(m_busy));
            check("cyc_ready", 32'(ready), 32'(!m_busy));
            check("cyc_valid", 32'(valid), 32'(m_valid));
            check("cyc_diff",  32'(diff),  32'(m_diff));
            check("cyc_bout",  32'(bout),  32'(m_bout));
            check("cyc_ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    // Called at the negedge right after an accept edge (or later, with a
    // correspondingly smaller exp_lat); waits for valid with a bound.
    task automatic wait_done(input string name, input int exp_lat,
                             input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat = 0;
        int bc  = 0;
        while (!valid && lat < 40) begin
            if (busy) bc++;
            lat++;
            @(negedge clk);
        end
        check({name, "_lat"},  32'(lat),  32'(exp_lat));
        check({name, "_busy"}, 32'(bc),   32'(exp_lat));
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_bout"}, 32'(bout), 32'(eb));
        check({name, "_ovf"},  32'(ovf),  32'(eo));
        check({name, "_mdl"},  32'(m_diff), 32'(ed));
    endtask

    initial begin
        int lat;
        #1;
        check("rst_diff",  32'(diff),  32'h0);
        check("rst_bout",  32'(bout),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_ovf",   32'(ovf),   32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 16-bit / 4-bit digits
        a2 = 16'h1234; b2 = 16'h0235; bin2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = '0; b2 = '0;
        lat = 0;
        while (!valid2 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check("w16_lat",  32'(lat),   32'd4);
        check("w16_diff", 32'(diff2), 32'h0FFF);
        check("w16_bout", 32'(bout2), 32'h0);
        @(negedge clk);
        check("w16_vpulse", 32'(valid2), 32'h0);

        issue(8'h05, 8'h03, 1'b0); wait_done("t5m3",  8, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check("valid_one_cycle", 32'(valid), 32'h0);
        issue(8'h03, 8'h05, 1'b0); wait_done("t3m5",  8, 8'hFE, 1'b1, 1'b0);
        issue(8'h00, 8'h00, 1'b1); wait_done("t0m0b", 8, 8'hFF, 1'b1, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1); wait_done("tFFb",  8, 8'hFF, 1'b1, 1'b0);

        // start while busy is ignored
        issue(8'h10, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h20; b = 8'h02; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 5, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        check("ignore_no2nd", 32'(valid), 32'h0);

        // back-to-back: second start in the valid cycle
        issue(8'h80, 8'h01, 1'b0); wait_done("b2b_1", 8, 8'h7F, 1'b0, OVF_ON);
        issue(8'h7F, 8'h01, 1'b0); wait_done("b2b_2", 8, 8'h7E, 1'b0, 1'b0);

        // reset during RUN
        @(negedge clk);
        issue(8'h44, 8'h21, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_diff",  32'(diff),  32'h0);
        check("arst_bout",  32'(bout),  32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        check("arst_ready", 32'(ready), 32'h1);
        check("arst_busy",  32'(busy),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid) lat++;
        end
        check("arst_no_valid", 32'(lat), 32'h0);
        issue(8'h33, 8'h11, 1'b1); wait_done("post_rst", 8, 8'h21, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
